// File: rtl/reg_bank8.sv
// Eight-entry register bank feeding the 8:1 read mux, with per-entry valid
// flags and a one-entry-per-cycle clear-all sweep that rejects writes while busy.
module reg_bank8 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [2:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             clr,
  output logic             busy,
  output logic             wr_drop,
  output logic [7:0]       valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [7:0]       valid_q, valid_d;
  logic             wr_drop_q, wr_drop_d;
  logic             do_write;
  logic             do_clear;
  logic             start_sweep;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr) state_d = SWEEP;
      SWEEP:   if (ptr_q == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded controls; busy comes straight from the state flop
  always_comb begin
    busy        = (state_q == SWEEP);
    do_write    = (state_q == IDLE) && we;
    start_sweep = (state_q == IDLE) && clr;
    do_clear    = (state_q == SWEEP);
  end

  // Datapath next values; a same-edge write in IDLE lands before the sweep starts
  always_comb begin
    mem_d     = mem_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    wr_drop_d = do_clear && we;
    if (do_write) begin
      mem_d[wa]   = wd;
      valid_d[wa] = 1'b1;
    end
    if (do_clear) begin
      mem_d[ptr_q]   = '0;
      valid_d[ptr_q] = 1'b0;
      ptr_d          = ptr_q + 3'd1;
    end else if (start_sweep) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
      valid_q   <= '0;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign valid   = valid_q;
  assign wr_drop = wr_drop_q;
  assign a       = mem_q[0];
  assign b       = mem_q[1];
  assign c       = mem_q[2];
  assign d       = mem_q[3];
  assign e       = mem_q[4];
  assign f       = mem_q[5];
  assign g       = mem_q[6];
  assign h       = mem_q[7];

endmodule

// File: doc/reg_bank8.md
Name: reg_bank8

Overview:
Eight-entry, 16-bit register bank that directly feeds the 8:1 read mux. The bank drives that mux's data inputs a..h.
- Single synchronous write port with address decode.
- Per-entry valid flags.
- Sequenced clear-all sweep that wipes one entry per cycle and reports busy.
- Sits directly upstream of the read mux; the mux select still chooses which entry is read.

Parameters:
WIDTH, 16, data width of each entry and of wd/a..h.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
we  input  1  write enable, sampled on rising clk
wa  input  3  write address, 0..7 selects entry a..h
wd  input  WIDTH  write data
clr  input  1  request clear-all sweep, sampled on rising clk
busy  output  1  high while clear sweep in progress
wr_drop  output  1  one-cycle pulse: a write was rejected because busy
valid  output  8  bit i = entry i written since last clear/reset
a,b,c,d,e,f,g,h  output  WIDTH  entry 0..7 contents, registered, to mux inputs a..h

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all entries = 0, valid = 8'h00, busy = 0, wr_drop = 0
  - state = IDLE, sweep pointer ptr = 0
  - releasing reset takes effect on the next rising edge
- States: IDLE, SWEEP. ptr is a 3-bit counter.
- IDLE, we=1, clr=0:
  - entry[wa] <= wd and valid[wa] <= 1 on that edge
  - new value visible on outputs after the edge, so write-to-output latency is 1 cycle
  - other entries unchanged
- IDLE, clr=1:
  - next state SWEEP, ptr <= 0, busy <= 1 on that edge
  - if we=1 on the same edge, the write is performed too; the sweep subsequently clears it
- SWEEP, every edge:
  - entry[ptr] <= 0, valid[ptr] <= 0, ptr <= ptr+1
  - when ptr=7, the clear of entry 7 completes, state <= IDLE, busy <= 0, ptr wraps to 0
  - busy is high for exactly 8 cycles; first write accepted on the edge after busy falls
- SWEEP, we=1:
  - write ignored (no entry or valid change)
  - wr_drop = 1 for the cycle following that edge
  - wr_drop = 0 otherwise
- SWEEP, clr=1: ignored; no restart, no extension of busy.
- Entries not yet reached by the sweep keep their old value and valid until their turn.
- Reset asserted mid-sweep: immediate return to reset values; the sweep is abandoned.
- wa is always in range (3 bits). Same-address back-to-back writes: the last write wins.
- Outputs change only on a clk edge or reset, never combinationally from inputs.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release → a..h=0, valid=8'h00, busy=0, wr_drop=0.
- Write each entry: we=1, wa=0..7, wd=16'h1000+wa on consecutive cycles → after 8 edges a=16'h1000 … h=16'h1007, valid=8'hFF; each value appears one edge after its write.
- Overwrite: write wa=3 with 16'hBEEF, then 16'h1234 on the next edge → d=16'h1234, others unchanged.
- Clear sweep: with all entries valid, pulse clr for one cycle:
  - busy is high for exactly 8 cycles
  - entry k reads 0 and valid[k]=0 after sweep edge k+1, while higher entries still hold data
  - at the end, valid=8'h00 and busy=0
- Write during sweep: we=1, wa=5, wd=16'hAAAA on the 3rd busy cycle → wr_drop pulses one cycle, f=0 after sweep; a write to wa=5 on the first cycle after busy=0 → f=16'hAAAA, valid[5]=1.
- Simultaneous clr+we in IDLE, plus reset mid-sweep:
  - clr=1 with we=1, wa=7, wd=16'h5555 → h=16'h5555 until sweep edge 8, then 0
  - repeat the clr and drop rst_n at busy cycle 4 → immediate reset values, busy=0, no residual sweep after release
